vmem_fill_ctrl: RTL

- Memory-mapped rectangle-fill engine plus write-port arbiter for the 3-bit/pixel VMEM that feeds the ST7789 display.
- Sits between the CPU data bus and the VMEM write port. CPU stores pass straight through; the engine uses the port when the CPU does not.
- Software programs a rectangle and a colour, then starts the fill. The engine writes one pixel per free cycle, so software does not have to loop over 57,600 store instructions.

---
 rtl/vmem_fill_ctrl.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/vmem_fill_ctrl.sv
// ---------------------------------------------------------------------------
// vmem_fill_ctrl
//
// Rectangle-fill engine and write-port arbiter for the 3-bit/pixel VMEM that
// feeds the ST7789 display. Software programs a rectangle (XY, WH) and a
// colour, then writes start; the engine writes one pixel into VMEM on every
// cycle the CPU is not storing to VMEM itself.
//
// Ports:
//   clk_i, rst_i          system clock, synchronous active-high reset
//   cfg_we_i              config register write strobe (address-qualified)
//   cfg_addr_i[3:0]       byte offset, [3:2] selects CTRL/XY/WH/COLOR
//   cfg_wdata_i[31:0]     config write data
//   cfg_rdata_o[31:0]     registered config read data (1 cycle latency)
//   cpu_we_i              CPU VMEM store strobe, always has priority
//   cpu_addr_i[15:0]      CPU VMEM address {y, x}
//   cpu_wdata_i[2:0]      CPU pixel colour
//   vmem_we_o             VMEM write enable
//   vmem_addr_o[15:0]     VMEM address {y, x}
//   vmem_wdata_o[2:0]     VMEM colour
//   busy_o                high from start acceptance to the end of DONE
//   done_o                one-cycle pulse when a fill completes
// ---------------------------------------------------------------------------
module vmem_fill_ctrl #(
    parameter int SCREEN_W = 240,
    parameter int SCREEN_H = 240
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cfg_we_i,
    input  logic [3:0]  cfg_addr_i,
    input  logic [31:0] cfg_wdata_i,
    output logic [31:0] cfg_rdata_o,
    input  logic        cpu_we_i,
    input  logic [15:0] cpu_addr_i,
    input  logic [2:0]  cpu_wdata_i,
    output logic        vmem_we_o,
    output logic [15:0] vmem_addr_o,
    output logic [2:0]  vmem_wdata_o,
    output logic        busy_o,
    output logic        done_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        FILL  = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [8:0] SCREEN_W9 = 9'(SCREEN_W);
    localparam logic [8:0] SCREEN_H9 = 9'(SCREEN_H);

    state_e      state_q;
    logic [15:0] xy_q;
    logic [15:0] wh_q;
    logic [2:0]  color_q;
    logic        doneSticky_q;
    logic [7:0]  x0_q;
    logic [7:0]  xe_q;
    logic [7:0]  ye_q;
    logic [7:0]  x_q;
    logic [7:0]  y_q;
    logic [2:0]  fillColor_q;

    logic        ctrlWrite;
    logic        startReq;
    logic        abortReq;
    logic [8:0]  xSum;
    logic [8:0]  ySum;
    logic [8:0]  xEnd;
    logic [8:0]  yEnd;
    logic [7:0]  xeClip_d;
    logic [7:0]  yeClip_d;
    logic        emptyRect;
    logic        unusedCfgBits;

    // Control-register decode. Abort dominates start, so a write carrying
    // both bits never launches a fill.
    assign ctrlWrite = cfg_we_i && (cfg_addr_i[3:2] == 2'd0);
    assign abortReq  = ctrlWrite && cfg_wdata_i[1];
    assign startReq  = ctrlWrite && cfg_wdata_i[0] && !cfg_wdata_i[1];

    // Clipped inclusive end coordinates. The sums are 9 bits wide so that a
    // start near 255 plus a large width cannot wrap before the clamp. When
    // the rectangle is empty these values are never used.
    assign xSum      = {1'b0, xy_q[7:0]}  + {1'b0, wh_q[7:0]};
    assign ySum      = {1'b0, xy_q[15:8]} + {1'b0, wh_q[15:8]};
    assign xEnd      = (xSum > SCREEN_W9) ? SCREEN_W9 : xSum;
    assign yEnd      = (ySum > SCREEN_H9) ? SCREEN_H9 : ySum;
    assign xeClip_d  = 8'(xEnd - 9'd1);
    assign yeClip_d  = 8'(yEnd - 9'd1);
    assign emptyRect = (wh_q[7:0] == 8'd0) || (wh_q[15:8] == 8'd0) ||
                       ({1'b0, xy_q[7:0]} >= SCREEN_W9) ||
                       ({1'b0, xy_q[15:8]} >= SCREEN_H9);

    // Upper write-data bits and the byte-lane address bits carry no meaning
    // for any register; they are folded together here only so that they are
    // visibly consumed.
    assign unusedCfgBits = ^{cfg_wdata_i[31:16], cfg_addr_i[1:0]};

    // Software-visible parameter registers. They may be rewritten during a
    // fill; the running fill keeps the copies it latched in SETUP.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            xy_q    <= '0;
            wh_q    <= '0;
            color_q <= '0;
        end else if (cfg_we_i) begin
            case (cfg_addr_i[3:2])
                2'd1:    xy_q    <= cfg_wdata_i[15:0];
                2'd2:    wh_q    <= cfg_wdata_i[15:0];
                2'd3:    color_q <= cfg_wdata_i[2:0];
                default: ;
            endcase
        end
    end

    // Registered read port: the value reflects the register contents during
    // the cycle the address was presented. Unused bits read as zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cfg_rdata_o <= '0;
        end else begin
            case (cfg_addr_i[3:2])
                2'd0:    cfg_rdata_o <= {30'd0, doneSticky_q, busy_o};
                2'd1:    cfg_rdata_o <= {16'd0, xy_q};
                2'd2:    cfg_rdata_o <= {16'd0, wh_q};
                default: cfg_rdata_o <= {29'd0, color_q};
            endcase
        end
    end

    // Fill sequencer. busy_o and done_o are registered alongside the state so
    // they line up exactly with SETUP/FILL/DONE. In FILL the pixel counters
    // only advance on cycles where the engine actually owns the port, which is
    // what makes a CPU store a pure stall rather than a skipped pixel.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            doneSticky_q <= 1'b0;
            x0_q         <= '0;
            xe_q         <= '0;
            ye_q         <= '0;
            x_q          <= '0;
            y_q          <= '0;
            fillColor_q  <= '0;
        end else begin
            done_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (startReq) begin
                        state_q      <= SETUP;
                        busy_o       <= 1'b1;
                        doneSticky_q <= 1'b0;
                    end
                end
                SETUP: begin
                    x0_q        <= xy_q[7:0];
                    x_q         <= xy_q[7:0];
                    y_q         <= xy_q[15:8];
                    xe_q        <= xeClip_d;
                    ye_q        <= yeClip_d;
                    fillColor_q <= color_q;
                    if (abortReq) begin
                        state_q <= IDLE;
                        busy_o  <= 1'b0;
                    end else if (emptyRect) begin
                        state_q <= DONE;
                        done_o  <= 1'b1;
                    end else begin
                        state_q <= FILL;
                    end
                end
                FILL: begin
                    if (abortReq) begin
                        state_q <= IDLE;
                        busy_o  <= 1'b0;
                    end else if (!cpu_we_i) begin
                        if (x_q == xe_q) begin
                            if (y_q == ye_q) begin
                                state_q <= DONE;
                                done_o  <= 1'b1;
                            end else begin
                                x_q <= x0_q;
                                y_q <= y_q + 8'd1;
                            end
                        end else begin
                            x_q <= x_q + 8'd1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_o  <= 1'b0;
                    if (!abortReq) begin
                        doneSticky_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

    // Write-port arbiter. The CPU always wins in the same cycle; the engine
    // drives the port only in FILL when the CPU is quiet.
    always_comb begin
        vmem_we_o    = 1'b0;
        vmem_addr_o  = '0;
        vmem_wdata_o = '0;
        if (cpu_we_i) begin
            vmem_we_o    = 1'b1;
            vmem_addr_o  = cpu_addr_i;
            vmem_wdata_o = cpu_wdata_i;
        end else if (state_q == FILL) begin
            vmem_we_o    = 1'b1;
            vmem_addr_o  = {y_q, x_q};
            vmem_wdata_o = fillColor_q;
        end
    end

endmodule
